sam_sequencer: RTL and testbench

SAM_SEQUENCER -- requirements
Module: sam_sequencer

---
 rtl/sam_pkg.sv | 87 ++++++++
 rtl/sam_ctrl_rom.sv | 36 +++
 rtl/sam_sequencer.sv | 152 +++++++++++++++
 tb/tb_sam_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sam_pkg.sv
// ============================================================================
// sam_pkg -- shared states, control-bit map, opcodes and control words.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sam_pkg;

  localparam int CW_W = 22;
  typedef logic [CW_W-1:0] ctrl_word_t;

  localparam logic [7:0] DWELL_MAX = 8'hFF;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_F_ADDR   = 4'd1,
    S_F_MEM    = 4'd2,
    S_F_LATCH  = 4'd3,
    S_F_IR     = 4'd4,
    S_DEC      = 4'd5,
    S_OP_MEM   = 4'd6,
    S_OP_LATCH = 4'd7,
    S_LD_EX    = 4'd8,
    S_ADD_EX   = 4'd9,
    S_ST_MBR   = 4'd10,
    S_ST_MEM   = 4'd11,
    S_BR_T     = 4'd12
  } state_t;

  // Datapath control-bit positions within b.
  localparam int B_PC_ABUS  = 21;
  localparam int B_IR_ABUS  = 20;
  localparam int B_MBR_IBUS = 19;
  localparam int B_MBR_ALU  = 18;
  localparam int B_AC_ALU   = 17;
  localparam int B_ALU_EN   = 16;
  localparam int B_ALU_ADD  = 15;
  localparam int B_ALU_PASS = 14;
  localparam int B_MEM_EN   = 13;
  localparam int B_MEM_WR   = 12;
  localparam int B_IR_LD    = 11;
  localparam int B_ABUS_MAR = 10;
  localparam int B_MEM_MBR  = 9;
  localparam int B_AC_MBR   = 8;
  localparam int B_AC_LD    = 7;
  localparam int B_PC_CLR   = 6;
  localparam int B_PC_INC   = 5;
  localparam int B_ABUS_PC  = 4;
  localparam int B_MEM_RD   = 3;
  localparam int B_MEM_REQ  = 2;
  localparam int B_MBR_WBUS = 1;
  localparam int B_ALU_RBUS = 0;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_BRN   = 2'b11;

  localparam ctrl_word_t CW_ONE = 22'd1;

  localparam ctrl_word_t CW_RST      = (CW_ONE << B_PC_CLR);
  localparam ctrl_word_t CW_F_ADDR   = (CW_ONE << B_PC_ABUS) | (CW_ONE << B_ABUS_MAR);
  localparam ctrl_word_t CW_F_MEM    = (CW_ONE << B_MEM_EN) | (CW_ONE << B_MEM_RD)
                                     | (CW_ONE << B_MEM_REQ);
  localparam ctrl_word_t CW_F_LATCH  = (CW_ONE << B_MEM_MBR) | (CW_ONE << B_PC_INC);
  localparam ctrl_word_t CW_F_IR     = (CW_ONE << B_MBR_IBUS) | (CW_ONE << B_IR_LD);
  localparam ctrl_word_t CW_DEC      = (CW_ONE << B_IR_ABUS) | (CW_ONE << B_ABUS_MAR);
  localparam ctrl_word_t CW_OP_MEM   = CW_F_MEM;
  localparam ctrl_word_t CW_OP_LATCH = (CW_ONE << B_MEM_MBR);
  localparam ctrl_word_t CW_LD_EX    = (CW_ONE << B_MBR_ALU) | (CW_ONE << B_ALU_EN)
                                     | (CW_ONE << B_ALU_PASS) | (CW_ONE << B_AC_LD)
                                     | (CW_ONE << B_ALU_RBUS);
  localparam ctrl_word_t CW_ADD_EX   = (CW_ONE << B_MBR_ALU) | (CW_ONE << B_AC_ALU)
                                     | (CW_ONE << B_ALU_EN) | (CW_ONE << B_ALU_ADD)
                                     | (CW_ONE << B_AC_LD) | (CW_ONE << B_ALU_RBUS);
  localparam ctrl_word_t CW_ST_MBR   = (CW_ONE << B_AC_MBR) | (CW_ONE << B_MBR_WBUS);
  localparam ctrl_word_t CW_ST_MEM   = (CW_ONE << B_MEM_EN) | (CW_ONE << B_MEM_WR)
                                     | (CW_ONE << B_MEM_REQ);
  localparam ctrl_word_t CW_BR_T     = (CW_ONE << B_IR_ABUS) | (CW_ONE << B_ABUS_PC);

  function automatic logic is_mem_state(input state_t s);
    return (s == S_F_MEM) || (s == S_OP_MEM) || (s == S_ST_MEM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sam_ctrl_rom.sv
// ============================================================================
// sam_ctrl_rom -- combinational state-to-control-word lookup.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sam_ctrl_rom
  import sam_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = CW_RST;
    case (state)
      S_RST:      cw = CW_RST;
      S_F_ADDR:   cw = CW_F_ADDR;
      S_F_MEM:    cw = CW_F_MEM;
      S_F_LATCH:  cw = CW_F_LATCH;
      S_F_IR:     cw = CW_F_IR;
      S_DEC:      cw = CW_DEC;
      S_OP_MEM:   cw = CW_OP_MEM;
      S_OP_LATCH: cw = CW_OP_LATCH;
      S_LD_EX:    cw = CW_LD_EX;
      S_ADD_EX:   cw = CW_ADD_EX;
      S_ST_MBR:   cw = CW_ST_MBR;
      S_ST_MEM:   cw = CW_ST_MEM;
      S_BR_T:     cw = CW_BR_T;
      default:    cw = CW_RST;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sam_sequencer.sv
// ============================================================================
// sam_sequencer -- Moore control sequencer for the SAM datapath.
// Optional wait-timeout abort is built when SAM_SEQ_WAIT_TIMEOUT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sam_sequencer
  import sam_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_wait,
  input  logic            ir15,
  input  logic            ir14,
  input  logic            ac15,
  output logic [CW_W-1:0] b,
  output logic            instr_done,
  output logic            bus_err
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range_check
    $error("sam_sequencer: TIMEOUT must be in 2..255");
  end

  state_t     state_q, state_d;
  logic       op_add_q, op_add_d;
  logic [7:0] dwell_q, dwell_d;
  ctrl_word_t b_q, b_d;
  logic       instr_done_q, instr_done_d;

  logic       in_mem;
  logic       mem_ready;
  logic       abort;
  logic [1:0] opcode;

  assign opcode = {ir15, ir14};

`ifdef SAM_SEQ_WAIT_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q;
`endif

  always_comb begin
    state_d      = state_q;
    op_add_d     = op_add_q;
    dwell_d      = dwell_q;
    abort        = 1'b0;
    instr_done_d = 1'b0;
    in_mem       = is_mem_state(state_q);
    // A memory state lasts at least two cycles; dwell_q is zero in the first.
    mem_ready    = in_mem && (dwell_q != 8'd0) && !mem_wait;

    if (in_mem && (dwell_q != DWELL_MAX)) begin
      dwell_d = dwell_q + 8'd1;
    end

    case (state_q)
      S_RST:      state_d = S_F_ADDR;
      S_F_ADDR:   state_d = S_F_MEM;
      S_F_MEM:    if (mem_ready) state_d = S_F_LATCH;
      S_F_LATCH:  state_d = S_F_IR;
      S_F_IR:     state_d = S_DEC;
      S_DEC: begin
        op_add_d = (opcode == OP_ADD);
        case (opcode)
          OP_LOAD,
          OP_ADD:   state_d = S_OP_MEM;
          OP_STORE: state_d = S_ST_MBR;
          OP_BRN:   state_d = ac15 ? S_BR_T : S_F_ADDR;
          default:  state_d = S_F_ADDR;
        endcase
      end
      S_OP_MEM:   if (mem_ready) state_d = S_OP_LATCH;
      S_OP_LATCH: state_d = op_add_q ? S_ADD_EX : S_LD_EX;
      S_ST_MBR:   state_d = S_ST_MEM;
      S_ST_MEM:   if (mem_ready) state_d = S_F_ADDR;
      default:    state_d = S_F_ADDR;
    endcase

`ifdef SAM_SEQ_WAIT_TIMEOUT_EN
    wait_d = 8'd0;
    if (in_mem && mem_wait) begin
      if (wait_q == TIMEOUT_LAST) begin
        abort   = 1'b1;
        state_d = S_F_ADDR;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end
`endif

    if (state_d != state_q) begin
      dwell_d = 8'd0;
    end

    // Completion is flagged on the return to fetch, never after RST or an abort.
    if ((state_d == S_F_ADDR) && !abort &&
        (state_q inside {S_LD_EX, S_ADD_EX, S_BR_T, S_DEC, S_ST_MEM})) begin
      instr_done_d = 1'b1;
    end
  end

  sam_ctrl_rom u_ctrl_rom (
    .state (state_d),
    .cw    (b_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RST;
      op_add_q     <= 1'b0;
      dwell_q      <= 8'd0;
      b_q          <= CW_RST;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_add_q     <= op_add_d;
      dwell_q      <= dwell_d;
      b_q          <= b_d;
      instr_done_q <= instr_done_d;
    end
  end

`ifdef SAM_SEQ_WAIT_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      bus_err_q <= abort;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign b          = b_q;
  assign instr_done = instr_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sam_sequencer.sv
// ============================================================================
// tb_sam_sequencer -- directed and randomized checks of sam_sequencer against
// an instruction-level sequencing model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sam_sequencer;

  localparam int TMO = 8;
`ifdef SAM_SEQ_WAIT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam logic [21:0] W_RST     = 22'h000040;
  localparam logic [21:0] W_FADDR   = 22'h200400;
  localparam logic [21:0] W_FMEM    = 22'h00200C;
  localparam logic [21:0] W_FLATCH  = 22'h000220;
  localparam logic [21:0] W_FIR     = 22'h080800;
  localparam logic [21:0] W_DEC     = 22'h100400;
  localparam logic [21:0] W_OPMEM   = 22'h00200C;
  localparam logic [21:0] W_OPLATCH = 22'h000200;
  localparam logic [21:0] W_LDEX    = 22'h054081;
  localparam logic [21:0] W_ADDEX   = 22'h078081;
  localparam logic [21:0] W_STMBR   = 22'h000102;
  localparam logic [21:0] W_STMEM   = 22'h003004;
  localparam logic [21:0] W_BRT     = 22'h100010;

  logic        clk = 1'b0;
  logic        rst, mem_wait, ir15, ir14, ac15;
  logic [21:0] b;
  logic        instr_done, bus_err;

  sam_sequencer #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_wait   (mem_wait),
    .ir15       (ir15),
    .ir14       (ir14),
    .ac15       (ac15),
    .b          (b),
    .instr_done (instr_done),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  // Model: current control word plus the words still to come in this instruction.
  logic [21:0] exp_b;
  bit          exp_done, exp_err;
  logic [21:0] plan[$];
  int          dwell, waitc;

  bit          chk_en, pin_valid, pin_done, pin_err;
  logic [21:0] pin_b;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("b", b, exp_b);
      chk("instr_done", {21'd0, instr_done}, {21'd0, exp_done});
      chk("bus_err", {21'd0, bus_err}, {21'd0, exp_err});
      if (pin_valid) begin
        chk("pin_b", b, pin_b);
        chk("pin_done", {21'd0, instr_done}, {21'd0, pin_done});
        chk("pin_err", {21'd0, bus_err}, {21'd0, pin_err});
      end
    end
  end

  function automatic bit is_mem_w(input logic [21:0] w);
    return (w == W_FMEM) || (w == W_STMEM);
  endfunction

  task automatic model_reset();
    exp_b = W_RST; plan.delete();
    exp_done = 1'b0; exp_err = 1'b0; dwell = 0; waitc = 0;
  endtask

  task automatic start_fetch();
    exp_b = W_FADDR;
    plan.delete();
    plan.push_back(W_FMEM); plan.push_back(W_FLATCH);
    plan.push_back(W_FIR);  plan.push_back(W_DEC);
    dwell = 0; waitc = 0;
  endtask

  task automatic model_step();
    logic [21:0] cur;
    cur = exp_b;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (is_mem_w(cur)) begin
      if (TMO_EN && mem_wait && (waitc + 1 >= TMO)) begin
        start_fetch();
        exp_err = 1'b1;
        return;
      end
      if (mem_wait || dwell == 0) begin
        dwell++;
        waitc = mem_wait ? waitc + 1 : 0;
        return;
      end
    end
    if (cur == W_DEC) begin
      plan.delete();
      case ({ir15, ir14})
        2'b00: begin plan.push_back(W_OPMEM); plan.push_back(W_OPLATCH); plan.push_back(W_LDEX); end
        2'b10: begin plan.push_back(W_OPMEM); plan.push_back(W_OPLATCH); plan.push_back(W_ADDEX); end
        2'b01: begin plan.push_back(W_STMBR); plan.push_back(W_STMEM); end
        default: if (ac15) plan.push_back(W_BRT);
      endcase
    end
    dwell = 0; waitc = 0;
    if (plan.size() == 0) begin
      exp_done = (cur != W_RST);
      start_fetch();
    end else begin
      exp_b = plan.pop_front();
    end
  endtask

  function automatic logic [1:0] rop();
    return 2'($urandom_range(0, 3));
  endfunction

  function automatic bit ra();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drives inputs for the coming edge, advances the model on it, and sets
  // the optional literal expectation for the cycle after it.
  task automatic tick(input bit r, input bit mw, input logic [1:0] op, input bit a,
                      input bit pv, input logic [21:0] pb, input bit pd, input bit pe);
    rst = r; mem_wait = mw; {ir15, ir14} = op; ac15 = a;
    if (r) begin
      model_reset();
      pin_valid = 1'b1; pin_b = W_RST; pin_done = 1'b0; pin_err = 1'b0;
    end
    @(posedge clk);
    if (r) model_reset(); else model_step();
    pin_valid = pv; pin_b = pb; pin_done = pd; pin_err = pe;
    #2;
  endtask

  task automatic step(input bit mw, input logic [1:0] op, input bit a,
                      input logic [21:0] pb, input bit pd);
    tick(1'b0, mw, op, a, 1'b1, pb, pd, 1'b0);
  endtask

  task automatic fetch();
    step(1'b0, rop(), ra(), W_FMEM, 1'b0);
    step(1'b0, rop(), ra(), W_FMEM, 1'b0);
    step(1'b0, rop(), ra(), W_FLATCH, 1'b0);
    step(1'b0, rop(), ra(), W_FIR, 1'b0);
    step(1'b0, rop(), ra(), W_DEC, 1'b0);
  endtask

  int pct[4] = '{15, 50, 80, 95};

  initial begin
    rst = 1'b0; mem_wait = 1'b0; ir15 = 1'b0; ir14 = 1'b0; ac15 = 1'b0;
    chk_en = 1'b0; pin_valid = 1'b0; pin_b = '0; pin_done = 1'b0; pin_err = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    @(posedge clk); #2;
    chk_en = 1'b1;

    // Reset, release, then a clean fetch.
    tick(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, W_RST, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, W_RST, 1'b0, 1'b0);
    step(1'b0, rop(), ra(), W_FADDR, 1'b0);
    fetch();

    // LOAD with memory busy for five edges inside OP_MEM.
    step(1'b1, 2'b00, 1'b0, W_OPMEM, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, rop(), ra(), W_OPMEM, 1'b0);
    step(1'b0, rop(), ra(), W_OPLATCH, 1'b0);
    step(1'b0, rop(), ra(), W_LDEX, 1'b0);
    step(1'b0, rop(), ra(), W_FADDR, 1'b1);
    fetch();

    // ADD.
    step(1'b0, 2'b10, 1'b0, W_OPMEM, 1'b0);
    step(1'b0, rop(), ra(), W_OPMEM, 1'b0);
    step(1'b0, rop(), ra(), W_OPLATCH, 1'b0);
    step(1'b0, rop(), ra(), W_ADDEX, 1'b0);
    step(1'b0, rop(), ra(), W_FADDR, 1'b1);
    fetch();

    // STORE.
    step(1'b0, 2'b01, 1'b0, W_STMBR, 1'b0);
    step(1'b0, rop(), ra(), W_STMEM, 1'b0);
    step(1'b0, rop(), ra(), W_STMEM, 1'b0);
    step(1'b0, rop(), ra(), W_FADDR, 1'b1);
    fetch();

    // Branch taken, then not taken.
    step(1'b0, 2'b11, 1'b1, W_BRT, 1'b0);
    step(1'b0, rop(), ra(), W_FADDR, 1'b1);
    fetch();
    step(1'b0, 2'b11, 1'b0, W_FADDR, 1'b1);

    // Reset asserted between edges while in F_MEM.
    step(1'b1, rop(), ra(), W_FMEM, 1'b0);
    step(1'b1, rop(), ra(), W_FMEM, 1'b0);
    tick(1'b1, 1'b1, 2'b00, 1'b0, 1'b1, W_RST, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, W_RST, 1'b0, 1'b0);
    step(1'b0, rop(), ra(), W_FADDR, 1'b0);
    fetch();

    // Memory stuck busy in F_MEM.
    step(1'b0, 2'b11, 1'b0, W_FADDR, 1'b1);
    step(1'b1, rop(), ra(), W_FMEM, 1'b0);
    if (TMO_EN) begin
      for (int i = 0; i < TMO - 1; i++) step(1'b1, rop(), ra(), W_FMEM, 1'b0);
      tick(1'b0, 1'b1, rop(), ra(), 1'b1, W_FADDR, 1'b0, 1'b1);
      step(1'b0, rop(), ra(), W_FMEM, 1'b0);
    end else begin
      for (int i = 0; i < 20; i++) step(1'b1, rop(), ra(), W_FMEM, 1'b0);
      step(1'b0, rop(), ra(), W_FLATCH, 1'b0);
    end

    // Randomized traffic with varying memory busy rates and occasional resets.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 249) == 0) begin
          tick(1'b1, ra(), rop(), ra(), 1'b1, W_RST, 1'b0, 1'b0);
          if (ra()) tick(1'b1, ra(), rop(), ra(), 1'b1, W_RST, 1'b0, 1'b0);
        end else begin
          tick(1'b0, ($urandom_range(0, 99) < pct[k]), rop(), ra(),
               1'b0, 22'd0, 1'b0, 1'b0);
        end
      end
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
